wb_grf: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs (W_*).
- Selects the writeback value by decoding the W-stage instruction and commits it to a 32x32 general register file.
- Serves two combinational read ports to the decode stage.
- Emits a registered one-cycle write trace and a write counter for bench and debug.

---
 rtl/wb_grf.sv | 85 ++++++++
 tb/tb_wb_grf.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// wb_grf: writeback-stage register file with source select, two async read ports and a write trace.
// Define WB_BYPASS_EN to forward the same-cycle writeback value onto the read ports.
module wb_grf #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_inStr,
    input  logic [31:0] W_PC8,
    input  logic [4:0]  W_writeReg_NUM,
    input  logic [31:0] W_dataOUT,
    input  logic [31:0] W_aluResult,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_data,
    output logic [31:0] write_count
);
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [31:0] regs [NREG];
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        isLink;
    logic        we;
    logic [31:0] wbData;
    logic [31:0] rsStored;
    logic [31:0] rtStored;
    logic        unusedInstrBits;

    assign opcode          = W_inStr[31:26];
    assign funct           = W_inStr[5:0];
    assign unusedInstrBits = ^W_inStr[25:6];
    assign isLink          = (opcode == OP_JAL) || (opcode == OP_SPECIAL && funct == FN_JALR);
    assign we              = !reset && (W_writeReg_NUM != 5'd0);

    always_comb wbData = (opcode == OP_LW) ? W_dataOUT : isLink ? W_PC8 : W_aluResult;

    assign rsStored = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    assign rtStored = (rt_addr == 5'd0) ? '0 : regs[rt_addr];

`ifdef WB_BYPASS_EN
    // we already excludes register 0, so a match never forwards into $zero
    always_comb rs_data = reset ? '0 : (we && rs_addr == W_writeReg_NUM) ? wbData : rsStored;
    always_comb rt_data = reset ? '0 : (we && rt_addr == W_writeReg_NUM) ? wbData : rtStored;
`else
    always_comb rs_data = reset ? '0 : rsStored;
    always_comb rt_data = reset ? '0 : rtStored;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[W_writeReg_NUM] <= wbData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= RESET_PC;
            trace_reg   <= '0;
            trace_data  <= '0;
            write_count <= '0;
        end else begin
            trace_valid <= we;
            if (we) begin
                trace_pc    <= W_PC;
                trace_reg   <= W_writeReg_NUM;
                trace_data  <= wbData;
                write_count <= write_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed self-checking bench for wb_grf; expectations follow WB_BYPASS_EN when defined.
module tb_wb_grf;
    logic        clk;
    logic        reset;
    logic [31:0] W_PC;
    logic [31:0] W_inStr;
    logic [31:0] W_PC8;
    logic [4:0]  W_writeReg_NUM;
    logic [31:0] W_dataOUT;
    logic [31:0] W_aluResult;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [31:0] write_count;

    int nChecks = 0;
    int nPass   = 0;

    wb_grf dut (
        .clk(clk), .reset(reset),
        .W_PC(W_PC), .W_inStr(W_inStr), .W_PC8(W_PC8), .W_writeReg_NUM(W_writeReg_NUM),
        .W_dataOUT(W_dataOUT), .W_aluResult(W_aluResult),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg(trace_reg),
        .trace_data(trace_data), .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [4:0] dst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] mem);
        W_inStr = instr;
        W_writeReg_NUM = dst;
        W_PC = pc;
        W_PC8 = pc + 32'd8;
        W_aluResult = alu;
        W_dataOUT = mem;
    endtask

    task automatic idle();
        drive(32'h0000_0000, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_rs", rs_data, 32'h0);
        check("reset_rt", rt_data, 32'h0);
        check("reset_valid", {31'b0, trace_valid}, 32'h0);
        check("reset_pc", trace_pc, 32'h0000_3000);
        check("reset_count", write_count, 32'h0);

        drive(32'h0109_4021, 5'd8, 32'h0000_3000, 32'h1234_5678, 32'hCAFE_0000);
        tick();
        idle();
        rs_addr = 5'd8;
        #1;
        check("addu_rs", rs_data, 32'h1234_5678);
        check("addu_valid", {31'b0, trace_valid}, 32'h1);
        check("addu_reg", {27'b0, trace_reg}, 32'd8);
        check("addu_data", trace_data, 32'h1234_5678);
        check("addu_pc", trace_pc, 32'h0000_3000);
        check("addu_count", write_count, 32'd1);

        drive(32'h8C09_0004, 5'd9, 32'h0000_3004, 32'h0000_0004, 32'hDEAD_BEEF);
        tick();
        idle();
        rt_addr = 5'd9;
        #1;
        check("lw_rt", rt_data, 32'hDEAD_BEEF);
        check("lw_trace", trace_data, 32'hDEAD_BEEF);

        drive(32'h0C00_0C00, 5'd31, 32'h0000_3000, 32'h0000_0055, 32'h0000_0066);
        tick();
        idle();
        rs_addr = 5'd31;
        #1;
        check("jal_rs", rs_data, 32'h0000_3008);
        check("jal_count", write_count, 32'd3);

        drive(32'h0220_F809, 5'd7, 32'h0000_3004, 32'h0000_0099, 32'h0000_0088);
        tick();
        idle();
        rs_addr = 5'd7;
        rt_addr = 5'd7;
        #1;
        check("jalr_rs", rs_data, 32'h0000_300C);
        check("jalr_rt_same", rt_data, 32'h0000_300C);

        drive(32'h0000_0021, 5'd0, 32'h0000_3010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        idle();
        rs_addr = 5'd0;
        #1;
        check("zero_rs", rs_data, 32'h0);
        check("zero_valid", {31'b0, trace_valid}, 32'h0);
        check("zero_count", write_count, 32'd4);
        check("zero_hold_reg", {27'b0, trace_reg}, 32'd7);
        check("zero_hold_data", trace_data, 32'h0000_300C);

        rs_addr = 5'd10;
        drive(32'h0000_0021, 5'd10, 32'h0000_3014, 32'hA5A5_A5A5, 32'h0);
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_same_cycle", rs_data, 32'hA5A5_A5A5);
`else
        check("bypass_same_cycle", rs_data, 32'h0);
`endif
        tick();
        idle();
        #1;
        check("bypass_next_cycle", rs_data, 32'hA5A5_A5A5);
        check("bypass_count", write_count, 32'd5);

        drive(32'h0000_0021, 5'd3, 32'h0000_3018, 32'h0000_0011, 32'h0);
        tick();
        #1;
        check("b2b_first_trace", trace_data, 32'h0000_0011);
        drive(32'h0000_0021, 5'd3, 32'h0000_301C, 32'h0000_0022, 32'h0);
        tick();
        idle();
        rs_addr = 5'd3;
        #1;
        check("b2b_second_trace", trace_data, 32'h0000_0022);
        check("b2b_second_pc", trace_pc, 32'h0000_301C);
        check("b2b_reg", rs_data, 32'h0000_0022);
        check("b2b_count", write_count, 32'd7);

        rs_addr = 5'd8;
        rt_addr = 5'd9;
        drive(32'h0000_0021, 5'd12, 32'h0000_3020, 32'h0000_0077, 32'h0);
        reset = 1'b1;
        #1;
        check("reset_force_rs", rs_data, 32'h0);
        check("reset_force_rt", rt_data, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        rs_addr = 5'd12;
        rt_addr = 5'd8;
        #1;
        check("rstw_reg12", rs_data, 32'h0);
        check("rstw_reg8", rt_data, 32'h0);
        check("rstw_count", write_count, 32'h0);
        check("rstw_valid", {31'b0, trace_valid}, 32'h0);
        check("rstw_pc", trace_pc, 32'h0000_3000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
